// File: rtl/snake_control.sv
// Snake game control FSM: init, per-frame body shift, grow/erase, redraw, food.
// Define PAUSE_EN to add a pause input that freezes the frame counter in S_WAIT.
module snake_control #(
    parameter int          INIT_LEN  = 4,
    parameter int          MAX_LEN   = 64,
    parameter logic [23:0] FRAME_DIV = 24'd3_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        isDead,
    input  logic        inc_length,
`ifdef PAUSE_EN
    input  logic        pause,
`endif
    output logic        ld_head,
    output logic        ld_q_def,
    output logic        inc_address,
    output logic        rst_address,
    output logic        draw_q,
    output logic        update_head,
    output logic        ld_head_into_prev,
    output logic        ld_q_into_curr,
    output logic        ld_prev_into_q,
    output logic        ld_curr_into_prev,
    output logic        draw_curr,
    output logic        food_en,
    output logic        lock,
    output logic        check_inc,
    output logic [3:0]  cnt_status,
    output logic [2:0]  dir,
    output logic [2:0]  colour,
    output logic [10:0] length,
    output logic        dead
);

    typedef enum logic [4:0] {
        S_RST, S_INIT, S_INITW, S_WAIT, S_UPD, S_HPREV, S_RD, S_LDC, S_WR,
        S_CHK, S_GROW, S_ERASE, S_DRST, S_DRD, S_DRAW, S_FOOD, S_DEAD
    } state_t;

    localparam logic [2:0]  UP     = 3'b100;
    localparam logic [2:0]  DOWN   = 3'b110;
    localparam logic [2:0]  LEFT   = 3'b000;
    localparam logic [2:0]  RIGHT  = 3'b001;
    localparam logic [10:0] INIT_L = 11'(INIT_LEN);
    localparam logic [10:0] MAX_L  = 11'(MAX_LEN);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] addr_q, addr_d;
    logic [10:0] len_q, len_d;
    logic [23:0] frame_q, frame_d;
    logic [2:0]  dir_q, dir_d;
    logic [14:0] ctrl_q, ctrl_d;
    logic [2:0]  colour_q, colour_d;
    logic [2:0]  dir_req;
    logic        dir_has;
    logic        frame_run;
    logic        last_seg;

`ifdef PAUSE_EN
    assign frame_run = !pause;
`else
    assign frame_run = 1'b1;
`endif

    assign last_seg = (addr_q == len_q - 11'd1);

    // Highest-priority key wins; its reverse of the current heading is dropped.
    always_comb begin
        dir_req = dir_q;
        dir_has = 1'b1;
        if (key_up)         dir_req = UP;
        else if (key_down)  dir_req = DOWN;
        else if (key_left)  dir_req = LEFT;
        else if (key_right) dir_req = RIGHT;
        else                dir_has = 1'b0;
        dir_d = dir_q;
        if (state_q != S_UPD && dir_has &&
            dir_req != (dir_q[2] ? dir_q ^ 3'b010 : dir_q ^ 3'b001))
            dir_d = dir_req;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        addr_d  = addr_q;
        len_d   = len_q;
        frame_d = frame_q;
        unique case (state_q)
            S_RST:   state_d = S_INIT;
            S_INIT: begin
                addr_d  = '0;
                state_d = S_INITW;
            end
            S_INITW: begin
                addr_d = addr_q + 11'd1;
                if (addr_q == INIT_L - 11'd1) begin
                    len_d   = INIT_L;
                    state_d = S_DRST;
                end
            end
            S_WAIT: begin
                if (frame_run) begin
                    if (frame_q == FRAME_DIV - 24'd1) begin
                        frame_d = '0;
                        state_d = isDead ? S_DEAD : S_UPD;
                    end else begin
                        frame_d = frame_q + 24'd1;
                    end
                end
            end
            S_UPD: begin
                addr_d  = '0;
                state_d = S_HPREV;
            end
            S_HPREV: state_d = S_RD;
            S_RD:    state_d = S_LDC;
            S_LDC:   state_d = S_WR;
            S_WR: begin
                addr_d  = addr_q + 11'd1;
                state_d = last_seg ? S_CHK : S_RD;
            end
            S_CHK:
                state_d = (inc_length && len_q < MAX_L) ? S_GROW : S_ERASE;
            S_GROW: begin
                len_d   = len_q + 11'd1;
                state_d = S_DRST;
            end
            S_ERASE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = S_DRST;
            end
            S_DRST: begin
                addr_d  = '0;
                state_d = S_DRD;
            end
            S_DRD:   state_d = S_DRAW;
            S_DRAW: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    addr_d  = addr_q + 11'd1;
                    state_d = last_seg ? S_FOOD : S_DRD;
                end
            end
            S_FOOD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = S_WAIT;
            end
            S_DEAD:  state_d = S_DEAD;
            default: state_d = S_RST;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up
    // with state_q in the same cycle.
    always_comb begin
        ctrl_d   = '0;
        colour_d = 3'b000;
        unique case (state_d)
            S_INIT:  ctrl_d[13:10] = 4'b1001;
            S_INITW: ctrl_d[12:11] = 2'b11;
            S_WAIT:  ctrl_d[1]     = 1'b1;
            S_UPD: begin
                ctrl_d[8]  = 1'b1;
                ctrl_d[10] = 1'b1;
            end
            S_HPREV: ctrl_d[7]     = 1'b1;
            S_LDC:   ctrl_d[6]     = 1'b1;
            S_WR: begin
                ctrl_d[5]  = 1'b1;
                ctrl_d[4]  = 1'b1;
                ctrl_d[11] = 1'b1;
            end
            S_CHK:   ctrl_d[0]     = 1'b1;
            S_GROW:  ctrl_d[5]     = 1'b1;
            S_ERASE: ctrl_d[3]     = 1'b1;
            S_DRST:  ctrl_d[10]    = 1'b1;
            S_DRAW: begin
                ctrl_d[9]  = 1'b1;
                ctrl_d[11] = (cnt_d == 4'd15);
                colour_d   = 3'b010;
            end
            S_FOOD: begin
                ctrl_d[2] = 1'b1;
                colour_d  = 3'b100;
            end
            S_DEAD:  ctrl_d[14]    = 1'b1;
            default: ctrl_d        = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RST;
            cnt_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            frame_q  <= '0;
            dir_q    <= UP;
            ctrl_q   <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            frame_q  <= frame_d;
            dir_q    <= dir_d;
            ctrl_q   <= ctrl_d;
            colour_q <= colour_d;
        end
    end

    assign {dead, ld_head, ld_q_def, inc_address, rst_address, draw_q,
            update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q,
            ld_curr_into_prev, draw_curr, food_en, lock, check_inc} = ctrl_q;
    assign cnt_status = cnt_q;
    assign dir        = dir_q;
    assign colour     = colour_q;
    assign length     = len_q;

endmodule

// File: doc/snake_control.md
SNAKE_CONTROL -- requirements
Module: snake_control

Interface
REQ-001 Parameter INIT_LEN, default 4: initial snake length, in segments.
REQ-002 Parameter MAX_LEN, default 64: length saturation limit, at most 2047.
REQ-003 Parameter FRAME_DIV, default 24'd3_000_000: clock cycles per game step.
REQ-004 clk  in  1  single clock; all logic on its posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 key_up, key_down, key_left, key_right  in  1 each  direction requests, level-sensitive.
REQ-007 isDead, inc_length  in  1 each  status from the datapath.
REQ-008 ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en, lock, check_inc  out  1 each  datapath controls.
REQ-009 cnt_status  out  4  pixel index within a 4x4 cell; x offset = cnt_status/4, y offset = cnt_status%4.
REQ-010 dir  out  3  direction encoding: UP=100, DOWN=110, LEFT=000, RIGHT=001.
REQ-011 colour  out  3  pixel colour: 000 during draw_curr, 010 during draw_q, 100 during food_en, otherwise 000.
REQ-012 length  out  11  current snake length.
REQ-013 dead  out  1  high in S_DEAD.

Function
REQ-014 Moore FSM: all outputs SHALL decode from state, cnt_status, length and address-count registers only, with no combinational input-to-output path.
REQ-015 States: S_RST, S_INIT, S_INITW, S_WAIT, S_UPD, S_HPREV, S_RD, S_LDC, S_WR, S_CHK, S_GROW, S_ERASE, S_DRST, S_DRD, S_DRAW, S_FOOD, S_DEAD.
REQ-016 S_RST, all outputs 0 -> S_INIT. S_INIT asserts ld_head and rst_address -> S_INITW.
REQ-017 S_INITW asserts ld_q_def and inc_address for INIT_LEN cycles, then sets length=INIT_LEN -> S_DRST.
REQ-018 S_WAIT asserts lock every cycle and counts the frame counter.
- Counter reaching FRAME_DIV-1 and isDead=1 -> S_DEAD.
- Counter reaching FRAME_DIV-1 and isDead=0 -> S_UPD, counter cleared.
REQ-019 S_UPD asserts update_head and rst_address -> S_HPREV. S_HPREV asserts ld_head_into_prev -> S_RD.
REQ-020 Shift loop, 3 cycles per segment, SHALL run for segments 0..length-1:
- S_RD: idle cycle covering the 1-cycle RAM read latency.
- S_LDC: asserts ld_q_into_curr.
- S_WR: asserts ld_prev_into_q, ld_curr_into_prev and inc_address.
- Exit from S_WR after segment length-1 -> S_CHK; otherwise -> S_RD.
REQ-021 S_CHK asserts check_inc.
- inc_length=1 and length<MAX_LEN -> S_GROW.
- Otherwise -> S_ERASE.
REQ-022 S_GROW asserts ld_prev_into_q, writing the old tail at address=length, and increments length -> S_DRST; no erase occurs.
REQ-023 S_ERASE asserts draw_curr for 16 cycles, cnt_status 0..15 -> S_DRST.
REQ-024 S_DRST asserts rst_address -> S_DRD.
- S_DRD: 1 latency cycle -> S_DRAW.
- S_DRAW: asserts draw_q for 16 cycles, cnt_status 0..15, with inc_address on cnt_status=15.
- After segment length-1 -> S_FOOD; otherwise -> S_DRD.
REQ-025 S_FOOD asserts food_en for 16 cycles, cnt_status 0..15 -> S_WAIT.
REQ-026 S_DEAD is terminal: all datapath controls 0, dead=1; only rst exits.
REQ-027 Direction register:
- Sampled every cycle.
- Priority up > down > left > right.
- A request for the direct reverse of the current dir SHALL be ignored.
- No key pressed holds dir.
- dir SHALL change only outside S_UPD, so update_head always sees a stable value.
REQ-028 cnt_status SHALL return to 0 on every state entry; length SHALL saturate at MAX_LEN.

Reset
REQ-029 rst=1 at any clock edge, including mid-loop, SHALL force state=S_RST, cnt_status=0, length=0, frame counter=0, dir=UP (100) and dead=0, and all outputs SHALL be 0 on the following cycle.

Configuration
REQ-030 With PAUSE_EN defined: add input pause (1 bit).
- pause=1 in S_WAIT freezes the frame counter and holds the state.
- pause is ignored in every other state.
REQ-031 Without PAUSE_EN: no pause port exists, and the frame counter always runs in S_WAIT.

Verification
REQ-032 Reset, then run with INIT_LEN=4 -> ld_q_def high for exactly 4 cycles, length=4, then 4x16 draw_q cycles, then 16 food_en cycles.
REQ-033 FRAME_DIV=8, idle keys -> update_head pulses once per step, each step followed by 12 shift cycles (3x4) and 16 draw_curr cycles.
REQ-034 inc_length=1 during S_CHK -> S_GROW, length 4->5, zero draw_curr cycles that step, and the next draw has 80 draw_q cycles.
REQ-035 dir=UP, assert key_down -> dir stays 100; assert key_left -> dir becomes 000.
REQ-036 isDead=1 at frame expiry -> dead=1 and no further update_head; rst mid-S_DRAW -> all outputs 0 the next cycle.
REQ-037 With PAUSE_EN defined, pause=1 in S_WAIT for 20 cycles -> no update_head during the pause; the frame counter resumes from its held value when pause drops.
